branch_sequencer: RTL and testbench

Parametrised control-step sequencer for conditional branch instructions (brzr, brnz, brpl, brmi). It drives the datapath's fetch and branch strobes from T0 to T6 and waits on a memory-ready handshake during fetch. It evaluates the branch condition from the bus into a CON flag and loads PC only when the branch is taken. It sits beside the datapath and replaces hand-sequenced strobes for the branch instruction class.

---
 rtl/branch_sequencer.sv | 148 ++++++++++++++
 tb/tb_branch_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// Control-step sequencer (T0..T6) for the brzr/brnz/brpl/brmi branch instruction class.
// Optional macro BRANCH_SKIP_EN: a not-taken legal branch goes from T3 straight to T6.
module branch_sequencer #(
    parameter int unsigned                 DATA_WIDTH    = 32,
    parameter int unsigned                 OPCODE_WIDTH  = 5,
    parameter logic [OPCODE_WIDTH-1:0]     BRANCH_OPCODE = OPCODE_WIDTH'(5'b10010)
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Start,
    input  logic                  MemReady,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    output logic                  PCout,
    output logic                  Zlowout,
    output logic                  MDRout,
    output logic                  MARin,
    output logic                  Zin,
    output logic                  PCin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  IncPC,
    output logic                  Read,
    output logic                  Gra,
    output logic                  Rout,
    output logic                  Cout,
    output logic                  CONin,
    output logic                  ADD,
    output logic                  Con,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Illegal
);
    localparam int unsigned C2_MSB = DATA_WIDTH - 12;

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    con_next;
    logic                    cond;
    logic                    legal;
    logic                    bus_zero;
    logic                    bus_msb;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [1:0]              c2;
    logic                    unused_ir;

    assign opcode    = IR[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign c2        = IR[C2_MSB -: 2];
    assign legal     = (opcode == BRANCH_OPCODE);
    assign bus_zero  = (BusMuxOut == '0);
    assign bus_msb   = BusMuxOut[DATA_WIDTH-1];
    assign unused_ir = ^IR;

    // Branch condition selected by C2[1:0]
    always_comb begin
        cond = 1'b0;
        case (c2)
            2'b00:   cond = bus_zero;
            2'b01:   cond = !bus_zero;
            2'b10:   cond = !bus_msb && !bus_zero;
            default: cond = bus_msb;
        endcase
    end

    // Next state and next Con; Con only changes on the T3 exit
    always_comb begin
        next_state = state;
        con_next   = Con;
        case (state)
            IDLE: if (Start) next_state = T0;
            T0:   next_state = T1;
            T1:   if (MemReady) next_state = T2;
            T2:   next_state = T3;
            T3: begin
                con_next = legal && cond;
                if (!legal) begin
                    next_state = IDLE;
`ifdef BRANCH_SKIP_EN
                end else if (!cond) begin
                    next_state = T6;
`endif
                end else begin
                    next_state = T4;
                end
            end
            T4:      next_state = T5;
            T5:      next_state = T6;
            T6:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state   <= IDLE;
            Con     <= 1'b0;
            PCout   <= 1'b0;
            Zlowout <= 1'b0;
            MDRout  <= 1'b0;
            MARin   <= 1'b0;
            Zin     <= 1'b0;
            PCin    <= 1'b0;
            MDRin   <= 1'b0;
            IRin    <= 1'b0;
            Yin     <= 1'b0;
            IncPC   <= 1'b0;
            Read    <= 1'b0;
            Gra     <= 1'b0;
            Rout    <= 1'b0;
            Cout    <= 1'b0;
            CONin   <= 1'b0;
            ADD     <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= next_state;
            Con     <= con_next;
            PCout   <= (next_state == T0) || (next_state == T4);
            Zlowout <= (next_state == T1) || (next_state == T6);
            MDRout  <= (next_state == T2);
            MARin   <= (next_state == T0);
            Zin     <= (next_state == T0) || (next_state == T5);
            PCin    <= (next_state == T1) || ((next_state == T6) && con_next);
            MDRin   <= (next_state == T1);
            IRin    <= (next_state == T2);
            Yin     <= (next_state == T4);
            IncPC   <= (next_state == T0);
            Read    <= (next_state == T1);
            Gra     <= (next_state == T3);
            Rout    <= (next_state == T3);
            Cout    <= (next_state == T5);
            CONin   <= (next_state == T3);
            ADD     <= (next_state == T5);
            Busy    <= (next_state != IDLE);
            Done    <= (next_state == T6);
        end
    end

    // IR is only loaded at the T2 exit, so the opcode check has to be combinational in T3
    assign Illegal = (state == T3) && !legal;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: per-cycle strobe vectors, Con, latency and Clear behaviour.
// Expected not-taken latency follows BRANCH_SKIP_EN when the bench is built with it.
module tb_branch_sequencer;
`ifdef BRANCH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int LAT_NT = SKIP ? 5 : 7;

    localparam int S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4, S_T4 = 5, S_T5 = 6, S_T6 = 7;

    // Bit positions inside the observed/expected output vector
    localparam int B_PCOUT = 19, B_ZLOW = 18, B_MDROUT = 17, B_MARIN = 16, B_ZIN = 15;
    localparam int B_PCIN = 14, B_MDRIN = 13, B_IRIN = 12, B_YIN = 11, B_INCPC = 10;
    localparam int B_READ = 9, B_GRA = 8, B_ROUT = 7, B_COUT = 6, B_CONIN = 5, B_ADD = 4;
    localparam int B_BUSY = 3, B_DONE = 2, B_ILL = 1, B_CON = 0;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        Start;
    logic        MemReady;
    logic [31:0] IR;
    logic [31:0] BusMuxOut;
    logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
    logic Read, Gra, Rout, Cout, CONin, ADD, Con, Busy, Done, Illegal;

    int   errors   = 0;
    int   checks   = 0;
    logic con_prev = 1'b0;

    branch_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady),
        .IR(IR), .BusMuxOut(BusMuxOut),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Rout(Rout), .Cout(Cout), .CONin(CONin), .ADD(ADD),
        .Con(Con), .Busy(Busy), .Done(Done), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [19:0] obs();
        return {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
                Read, Gra, Rout, Cout, CONin, ADD, Busy, Done, Illegal, Con};
    endfunction

    // Strobe table written from the step definitions of each control step
    function automatic logic [19:0] exp_vec(input int st, input logic c, input logic ill);
        logic [19:0] v;
        v        = '0;
        v[B_CON] = c;
        v[B_BUSY] = (st != S_IDLE);
        case (st)
            S_T0: begin v[B_PCOUT] = 1'b1; v[B_MARIN] = 1'b1; v[B_INCPC] = 1'b1; v[B_ZIN] = 1'b1; end
            S_T1: begin v[B_ZLOW] = 1'b1; v[B_PCIN] = 1'b1; v[B_READ] = 1'b1; v[B_MDRIN] = 1'b1; end
            S_T2: begin v[B_MDROUT] = 1'b1; v[B_IRIN] = 1'b1; end
            S_T3: begin v[B_GRA] = 1'b1; v[B_ROUT] = 1'b1; v[B_CONIN] = 1'b1; v[B_ILL] = ill; end
            S_T4: begin v[B_PCOUT] = 1'b1; v[B_YIN] = 1'b1; end
            S_T5: begin v[B_COUT] = 1'b1; v[B_ADD] = 1'b1; v[B_ZIN] = 1'b1; end
            S_T6: begin v[B_ZLOW] = 1'b1; v[B_PCIN] = c; v[B_DONE] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    // One instruction from Start back to IDLE; elat is the hand-computed Start-to-Done cycle count (0 = never)
    task automatic run_branch(input string tag, input logic [31:0] ir, input logic [31:0] bus,
                              input int waits, input logic econ, input logic eill,
                              input int elat, input bit poke);
        int   seq[$];
        int   t3_idx;
        int   done_at;
        logic c;
        seq.push_back(S_T0);
        for (int i = 0; i <= waits; i++) seq.push_back(S_T1);
        seq.push_back(S_T2);
        seq.push_back(S_T3);
        t3_idx = seq.size() - 1;
        if (!eill) begin
            if (!(SKIP && !econ)) begin
                seq.push_back(S_T4);
                seq.push_back(S_T5);
            end
            seq.push_back(S_T6);
        end
        seq.push_back(S_IDLE);

        IR        = ir;
        BusMuxOut = bus;
        MemReady  = (waits == 0);
        Start     = 1'b1;
        done_at   = 0;
        for (int k = 0; k < seq.size(); k++) begin
            step();
            Start    = poke && (k == 2);
            MemReady = (k >= waits + 1);
            c        = (k > t3_idx) ? econ : con_prev;
            check($sformatf("%s.cyc%0d", tag, k + 1), 32'(obs()), 32'(exp_vec(seq[k], c, eill)));
            if (Done && done_at == 0) done_at = k + 1;
        end
        Start    = 1'b0;
        MemReady = 1'b0;
        check({tag, ".latency"}, 32'(done_at), 32'(elat));
        con_prev = econ;
    endtask

    // Start an instruction, stop after cycle stop_k+1 and hit Clear between clock edges
    task automatic clear_mid(input string tag, input logic [31:0] ir, input logic [31:0] bus,
                             input int waits, input int stop_k);
        IR        = ir;
        BusMuxOut = bus;
        MemReady  = (waits == 0);
        Start     = 1'b1;
        for (int k = 0; k <= stop_k; k++) begin
            step();
            Start    = 1'b0;
            MemReady = (k >= waits + 1);
        end
        check({tag, ".busy_before"}, 32'(Busy), 32'd1);
        Clear = 1'b1;
        #2;
        check({tag, ".async"}, 32'(obs()), 32'd0);
        step();
        check({tag, ".held"}, 32'(obs()), 32'd0);
        Clear    = 1'b0;
        MemReady = 1'b0;
        con_prev = 1'b0;
        step();
        check({tag, ".idle"}, 32'(obs()), 32'd0);
    endtask

    initial begin
        Clear     = 1'b1;
        Start     = 1'b0;
        MemReady  = 1'b0;
        IR        = '0;
        BusMuxOut = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset", 32'(obs()), 32'd0);
        Clear = 1'b0;
        step();
        check("idle", 32'(obs()), 32'd0);

        // C2 sits at IR[20:19]; opcode 10010 at IR[31:27]
        run_branch("brnz_taken",  32'h91280023, 32'd5,        0, 1'b1, 1'b0, 7,      1'b0);
        run_branch("brzr_bus5",   32'h91200023, 32'd5,        0, 1'b0, 1'b0, LAT_NT, 1'b0);
        run_branch("brzr_bus0",   32'h91200023, 32'd0,        0, 1'b1, 1'b0, 7,      1'b0);
        run_branch("brpl_neg",    32'h91300023, 32'h80000000, 0, 1'b0, 1'b0, LAT_NT, 1'b0);
        run_branch("brmi_neg",    32'h91380023, 32'h80000000, 0, 1'b1, 1'b0, 7,      1'b0);
        run_branch("brpl_zero",   32'h91300023, 32'd0,        0, 1'b0, 1'b0, LAT_NT, 1'b0);
        run_branch("brmi_zero",   32'h91380023, 32'd0,        0, 1'b0, 1'b0, LAT_NT, 1'b0);
        run_branch("brpl_pos",    32'h91300023, 32'd5,        0, 1'b1, 1'b0, 7,      1'b0);
        run_branch("brnz_wait3",  32'h91280023, 32'd5,        3, 1'b1, 1'b0, 10,     1'b1);
        run_branch("illegal_op",  32'h19280023, 32'd5,        0, 1'b0, 1'b1, 0,      1'b0);
        run_branch("brnz_again",  32'h91280023, 32'd7,        0, 1'b1, 1'b0, 7,      1'b0);
        clear_mid("clear_t5",     32'h91280023, 32'd5, 0, 5);
        run_branch("brnz_post1",  32'h91280023, 32'd5,        0, 1'b1, 1'b0, 7,      1'b0);
        clear_mid("clear_t1wait", 32'h91280023, 32'd5, 5, 2);
        run_branch("brnz_post2",  32'h91280023, 32'd5,        0, 1'b1, 1'b0, 7,      1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
